// File: rtl/bus_pkg.sv
// Shared types and constants for the bus cycle controller.
// Holds the one-hot bus state encoding, direction/space constants,
// bus widths, the default wait-state limit and the latched request payload.
package bus_pkg;

  localparam int unsigned ADDR_W           = 20;
  localparam int unsigned DATA_W           = 8;
  localparam int unsigned WAIT_W           = 8;
  localparam int unsigned MAX_WAIT_DEFAULT = 15;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;
  localparam logic SPACE_MEM = 1'b0;
  localparam logic SPACE_IO  = 1'b1;

  typedef enum logic [6:0] {
    ST_IDLE    = 7'b000_0001,
    ST_T1      = 7'b000_0010,
    ST_T2      = 7'b000_0100,
    ST_T3      = 7'b000_1000,
    ST_TW      = 7'b001_0000,
    ST_T4      = 7'b010_0000,
    ST_HOLDING = 7'b100_0000
  } bus_state_t;

  // Request fields captured on acceptance and held for the whole bus cycle.
  typedef struct packed {
    logic              write;
    logic              iom;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter for one bus cycle.
// Ports: clk_i/rst_ni (sync active-low reset), clear_i restarts the count,
// incr_i adds one wait state (saturating), expired_o is high when the
// count equals MAX_WAIT.
module bus_wait_timer
  import bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic incr_i,
  output logic expired_o
);

  logic [WAIT_W-1:0] count_q, count_d;

  // Clear wins over increment; the count never wraps.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i && (count_q != '1)) begin
      count_d = count_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Bus initiator: runs single read/write T1-T4 cycles with READY wait states,
// a wait-state timeout, and HOLD/HLDA hand-over to an external master.
// Ports: CLK/RESET (sync active-low); core side req_* in, req_ready out
// (state and HOLD only), rsp_valid/rsp_err/rsp_rdata out; bus side
// ALE, RD, WR, IOM, DTR, DEN, Address (Z while HLDA), Data (bidirectional),
// READY and HOLD in, HLDA out.
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_iom,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic              IOM,
  output logic              DTR,
  output logic              DEN,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data,
  input  logic              READY,
  input  logic              HOLD,
  output logic              HLDA
);

  bus_state_t        state_q, state_d;
  bus_req_t          req_q, req_d;
  logic              ale_q, ale_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              den_q, den_d;
  logic              data_oe_q, data_oe_d;
  logic              hlda_q, hlda_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              wait_clr, wait_inc, wait_expired;

  bus_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .clear_i  (wait_clr),
    .incr_i   (wait_inc),
    .expired_o(wait_expired)
  );

  // Next-state and next-output decode; registered outputs follow the new state.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ale_d       = 1'b0;
    rd_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    den_d       = 1'b0;
    data_oe_d   = 1'b0;
    hlda_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    wait_clr    = 1'b0;
    wait_inc    = 1'b0;
    req_ready   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = !HOLD;
        if (HOLD) begin
          state_d = ST_HOLDING;
          hlda_d  = 1'b1;
        end else if (req_valid) begin
          state_d = ST_T1;
          req_d   = '{write: req_write, iom: req_iom, addr: req_addr, wdata: req_wdata};
          ale_d   = 1'b1;
        end
      end
      ST_T1, ST_T2: begin
        state_d   = (state_q == ST_T1) ? ST_T2 : ST_T3;
        wait_clr  = (state_q == ST_T1);
        den_d     = 1'b1;
        rd_n_d    = (req_q.write != BUS_READ);
        wr_n_d    = (req_q.write != BUS_WRITE);
        data_oe_d = (req_q.write == BUS_WRITE);
      end
      ST_T3, ST_TW: begin
        if (READY || wait_expired) begin
          // Write data stays on the bus through T4 for hold time.
          state_d     = ST_T4;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !READY;
          data_oe_d   = (req_q.write == BUS_WRITE);
          if (READY && (req_q.write == BUS_READ)) begin
            rsp_rdata_d = Data;
          end
        end else begin
          state_d   = ST_TW;
          wait_inc  = 1'b1;
          den_d     = 1'b1;
          rd_n_d    = (req_q.write != BUS_READ);
          wr_n_d    = (req_q.write != BUS_WRITE);
          data_oe_d = (req_q.write == BUS_WRITE);
        end
      end
      ST_T4: begin
        state_d = ST_IDLE;
      end
      ST_HOLDING: begin
        if (HOLD) begin
          hlda_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      ale_q       <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      den_q       <= 1'b0;
      data_oe_q   <= 1'b0;
      hlda_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      ale_q       <= ale_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      den_q       <= den_d;
      data_oe_q   <= data_oe_d;
      hlda_q      <= hlda_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ALE       = ale_q;
  assign RD        = rd_n_q;
  assign WR        = wr_n_q;
  assign DEN       = den_q;
  assign IOM       = req_q.iom;
  assign DTR       = req_q.write;
  assign HLDA      = hlda_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  // Bus released to the external master while HLDA is high.
  assign Address = hlda_q ? {ADDR_W{1'bz}} : req_q.addr;
  assign Data    = data_oe_q ? req_q.wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl with MAX_WAIT = 4.
module tb_bus_cycle_ctrl;
  import bus_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid, req_ready, req_write, req_iom;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        ALE, RD, WR, IOM, DTR, DEN, READY, HOLD, HLDA;
  wire  [19:0] addr_bus;
  wire  [7:0]  data_bus;

  logic        ext_drv;
  logic [19:0] ext_addr;
  logic [7:0]  ext_data;
  logic [7:0]  resp_byte;

  int checks;
  int errors;

  // Responder drives the read byte while RD is low; ext_drv models another master.
  assign data_bus = ext_drv ? ext_data : (!RD ? resp_byte : 8'bz);
  assign addr_bus = ext_drv ? ext_addr : 20'bz;

  bus_cycle_ctrl #(.MAX_WAIT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_iom(req_iom), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .DTR(DTR), .DEN(DEN),
    .Address(addr_bus), .Data(data_bus), .READY(READY), .HOLD(HOLD), .HLDA(HLDA)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        write;
    logic        iom;
    logic [19:0] addr;
    logic [7:0]  wdata;
    int          waits;  // READY-low samples before READY rises
    logic [7:0]  resp;
    int          lat;    // cycles from accept edge to rsp_valid
    logic        err;
    logic [7:0]  rdata;  // rsp_rdata expected after the cycle
  } vec_t;

  vec_t vecs[6];
  vec_t v_hold, v_t2, v_rst;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request at a falling edge; accepted on the next rising edge.
  task automatic issue(input vec_t v);
    req_valid = 1'b1;
    req_write = v.write;
    req_iom   = v.iom;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    resp_byte = v.resp;
    #1 chk_b("req_ready issue", req_ready, !HOLD);
  endtask

  // Called right after the accept edge; walks every bus cycle up to T4.
  task automatic track(input vec_t v, input int hold_at);
    for (int c = 1; c <= v.lat; c++) begin
      logic act;
      @(negedge CLK);
      if (c == 1) req_valid = 1'b0;
      act = (c >= 2) && (c < v.lat);
      chk_b($sformatf("ALE c%0d", c), ALE, c == 1);
      chk_b($sformatf("RD c%0d", c), RD, !(act && !v.write));
      chk_b($sformatf("WR c%0d", c), WR, !(act && v.write));
      chk_b($sformatf("DEN c%0d", c), DEN, act);
      chk_b($sformatf("IOM c%0d", c), IOM, v.iom);
      chk_b($sformatf("DTR c%0d", c), DTR, v.write);
      chk_b($sformatf("HLDA c%0d", c), HLDA, 1'b0);
      chk_v($sformatf("Address c%0d", c), addr_bus, v.addr);
      chk_b($sformatf("rsp_valid c%0d", c), rsp_valid, c == v.lat);
      if (v.write && c >= 2) chk_v($sformatf("Data c%0d", c), 20'(data_bus), 20'(v.wdata));
      if (c == v.lat) begin
        chk_b("rsp_err", rsp_err, v.err);
        chk_v("rsp_rdata T4", 20'(rsp_rdata), 20'(v.rdata));
      end
      if (c == hold_at) HOLD = 1'b1;
      READY = (c < 3) ? 1'b1 : ((c - 3) >= v.waits);
    end
    @(negedge CLK);
    chk_b("rsp_valid after", rsp_valid, 1'b0);
    chk_v("rsp_rdata after", 20'(rsp_rdata), 20'(v.rdata));
    chk_b("req_ready after", req_ready, !HOLD);
    READY = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    RESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_iom = 1'b0;
    req_addr = '0; req_wdata = '0; READY = 1'b1; HOLD = 1'b0;
    ext_drv = 1'b0; ext_addr = '0; ext_data = '0; resp_byte = '0;

    //           wr         iom        addr      wdata  waits resp   lat err   rdata
    vecs[0] = '{BUS_READ,  SPACE_MEM, 20'h12345, 8'h00, 0,   8'hA5, 4, 1'b0, 8'hA5};
    vecs[1] = '{BUS_WRITE, SPACE_IO,  20'h00080, 8'h3C, 3,   8'h00, 7, 1'b0, 8'hA5};
    vecs[2] = '{BUS_READ,  SPACE_MEM, 20'hFFFFF, 8'h00, 255, 8'h11, 8, 1'b1, 8'hA5};
    vecs[3] = '{BUS_READ,  SPACE_IO,  20'h00001, 8'h00, 2,   8'h5E, 6, 1'b0, 8'h5E};
    vecs[4] = '{BUS_WRITE, SPACE_MEM, 20'hABCDE, 8'hFF, 0,   8'h00, 4, 1'b0, 8'h5E};
    vecs[5] = '{BUS_READ,  SPACE_MEM, 20'h00000, 8'h00, 3,   8'h00, 7, 1'b0, 8'h00};
    v_hold  = '{BUS_READ,  SPACE_MEM, 20'h22222, 8'h00, 0,   8'hC7, 4, 1'b0, 8'hC7};
    v_t2    = '{BUS_READ,  SPACE_MEM, 20'h0F0F0, 8'h00, 1,   8'h96, 5, 1'b0, 8'h96};
    v_rst   = '{BUS_WRITE, SPACE_MEM, 20'h54321, 8'hC3, 255, 8'h00, 8, 1'b1, 8'h00};

    // Reset values
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_b("rst ALE", ALE, 1'b0);   chk_b("rst RD", RD, 1'b1);
    chk_b("rst WR", WR, 1'b1);     chk_b("rst IOM", IOM, 1'b0);
    chk_b("rst DTR", DTR, 1'b0);   chk_b("rst DEN", DEN, 1'b0);
    chk_b("rst HLDA", HLDA, 1'b0); chk_v("rst Address", addr_bus, 20'h0);
    chk_b("rst rsp_valid", rsp_valid, 1'b0);
    chk_b("rst rsp_err", rsp_err, 1'b0);
    chk_v("rst rsp_rdata", 20'(rsp_rdata), 20'h0);
    ext_drv = 1'b1; ext_data = 8'h5A;
    #1 chk_v("rst Data released", 20'(data_bus), 20'h5A);
    ext_drv = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);

    // Table of single transfers
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i]);
      @(posedge CLK);
      track(vecs[i], 0);
    end

    // HOLD in IDLE beats a pending request
    HOLD = 1'b1;
    issue(v_hold);
    @(negedge CLK);
    chk_b("hold HLDA", HLDA, 1'b1); chk_b("hold RD", RD, 1'b1);
    chk_b("hold WR", WR, 1'b1);     chk_b("hold ALE", ALE, 1'b0);
    ext_drv = 1'b1; ext_addr = 20'h0BEEF; ext_data = 8'h77;
    #1 chk_v("hold Address released", addr_bus, 20'h0BEEF);
    chk_v("hold Data released", 20'(data_bus), 20'h77);
    @(negedge CLK);
    chk_b("hold HLDA kept", HLDA, 1'b1);
    chk_b("hold req_ready", req_ready, 1'b0);
    ext_drv = 1'b0; HOLD = 1'b0;
    @(negedge CLK);
    chk_b("unhold HLDA", HLDA, 1'b0);
    chk_b("unhold req_ready", req_ready, 1'b1);
    @(posedge CLK);
    track(v_hold, 0);

    // HOLD raised during T2: cycle completes before HLDA
    issue(v_t2);
    @(posedge CLK);
    track(v_t2, 2);
    @(negedge CLK);
    chk_b("T2 hold HLDA after T4", HLDA, 1'b1);
    HOLD = 1'b0;
    @(negedge CLK);
    chk_b("T2 hold HLDA dropped", HLDA, 1'b0);

    // RESET during TW of a write
    issue(v_rst);
    @(posedge CLK);
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      if (c == 1) req_valid = 1'b0;
      READY = (c < 3);
    end
    chk_b("pre-reset WR", WR, 1'b0);
    chk_v("pre-reset Data", 20'(data_bus), 20'hC3);
    RESET = 1'b0;
    @(negedge CLK);
    chk_b("mid-rst WR", WR, 1'b1);   chk_b("mid-rst DEN", DEN, 1'b0);
    chk_b("mid-rst DTR", DTR, 1'b0); chk_v("mid-rst Address", addr_bus, 20'h0);
    chk_b("mid-rst rsp_valid", rsp_valid, 1'b0);
    chk_v("mid-rst rsp_rdata", 20'(rsp_rdata), 20'h0);
    chk_b("mid-rst req_ready", req_ready, 1'b1);
    ext_drv = 1'b1; ext_data = 8'h5A;
    #1 chk_v("mid-rst Data released", 20'(data_bus), 20'h5A);
    ext_drv = 1'b0; RESET = 1'b1; READY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk_b($sformatf("post-rst rsp_valid %0d", c), rsp_valid, 1'b0);
      chk_b($sformatf("post-rst WR %0d", c), WR, 1'b1);
    end

    // Recovery after reset
    issue(vecs[0]);
    @(posedge CLK);
    track(vecs[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
